rtc_timer_reader: RTL and testbench
===================================

// Module: rtc_timer_reader
// PURPOSE
//  Reads back the RTC countdown-timer registers (seconds, minutes, hours) that the
//  per-field write FSMs set. Runs address-phase / read-data-phase sequences on the
//  multiplexed RTC bus and presents a coherent BCD snapshot to the VGA display path.
//  Sits between the general control FSM (issues start) and the RTC bus driver (req/ack).
// PARAMETERS
//  BASE_ADDR   8'h41  address of timer seconds; minutes = BASE_ADDR+1, hours = BASE_ADDR+2
//  TIMEOUT     8'd255 max cycles waiting for ack_i in one phase before abort
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  reset       in   1  synchronous, active-high
//  start       in   1  one-cycle request for a snapshot; ignored when busy
//  req_o       out  1  bus request to RTC driver, held until ack_i
//  a_d_o       out  1  0 = address phase, 1 = data phase
//  rd_o        out  1  1 in data phase (read); 0 in address phase
//  dir_o       out  8  address in address phase; 8'h00 in data phase
//  ack_i       in   1  driver completed current phase; data_i valid when ack_i in data phase
//  data_i      in   8  BCD byte returned by RTC
//  seg_o       out  8  BCD seconds of last good snapshot
//  min_o       out  8  BCD minutes of last good snapshot
//  hor_o       out  8  BCD hours of last good snapshot
//  busy_o      out  1  1 from accepted start until done_o/err_o
//  done_o      out  1  one-cycle pulse: snapshot updated
//  err_o       out  1  one-cycle pulse: timeout or invalid BCD; snapshot unchanged
// BEHAVIOUR
//  - Reset: state IDLE; req_o, a_d_o, rd_o, busy_o, done_o, err_o = 0; dir_o, seg_o,
//    min_o, hor_o = 8'h00; index = 0; timeout counter = 0; shadow regs = 0.
//  - All outputs registered. start sampled only in IDLE; start while busy is dropped.
//  - FSM: IDLE -> ADDR -> DATA -> (NEXT) -> ADDR ... -> CHECK -> IDLE.
//    IDLE: start=1 -> ADDR, index=0, busy_o=1 next cycle.
//    ADDR: req_o=1, a_d_o=0, rd_o=0, dir_o=BASE_ADDR+index; ack_i=1 -> DATA.
//    DATA: req_o=1, a_d_o=1, rd_o=1, dir_o=0; ack_i=1 -> capture data_i into shadow[index];
//          index<2 -> index+1, ADDR; index==2 -> CHECK.
//    req_o deasserts for exactly one cycle between phases (driver sees a fresh edge).
//    CHECK: validate shadow: every nibble <=9, sec<=8'h59, min<=8'h59, hour<=8'h23.
//          Valid -> copy all three to seg_o/min_o/hor_o same cycle, done_o=1.
//          Invalid -> outputs unchanged, err_o=1. Either -> IDLE, busy_o=0.
//  - Latency with ack_i in first cycle of each phase: 6 phases x 2 cycles + CHECK
//    = done_o 13 cycles after start.
//  - Timeout: counter cleared on entering ADDR/DATA, +1 per cycle without ack_i;
//    reaching TIMEOUT -> err_o=1, req_o=0, IDLE; snapshot unchanged.
//  - ack_i outside ADDR/DATA ignored. ack_i in same cycle as timeout: ack wins.
//  - seg_o/min_o/hor_o only change together (never a mixed snapshot).
//  - reset mid-sequence: next cycle IDLE, req_o=0, snapshot cleared to 8'h00.
// STRUCTURE
//  - Shared package/header: phase encodings (ADDR_PHASE=0, DATA_PHASE=1), RTC register
//    addresses (timer sec/min/hour 8'h41..8'h43), BCD limits (8'h59, 8'h23).
//  - One sub-module: bcd_field_check (value, max -> ok), instantiated three times.
//  - Timeout counter and index counter inline in top FSM.
// TESTING
//  - Reset then start, ack_i=1 each phase, data 8'h45,8'h30,8'h12 -> dir_o 41,42,43
//    in ADDR phases; done_o at cycle 13; seg/min/hor = 45/30/12.
//  - ack_i delayed 5 cycles per phase -> req_o held steady, correct capture, done_o once.
//  - data 8'h5A for seconds -> err_o pulse, seg/min/hor keep previous 45/30/12.
//  - No ack in minutes ADDR -> err_o exactly TIMEOUT cycles after phase entry, req_o=0.
//  - start pulsed while busy -> ignored; exactly one done_o; hours 8'h24 -> err_o.
//  - reset asserted in DATA phase -> next cycle IDLE, req_o=0, all outputs 8'h00.

Source files
------------

// File: rtl/rtc_timer_reader_pkg.sv
// Shared constants and types for the RTC countdown-timer snapshot reader.
// Phase encodings, timer register address, BCD limits and FSM states.
package rtc_timer_reader_pkg;

   localparam logic       ADDR_PHASE   = 1'b0;
   localparam logic       DATA_PHASE   = 1'b1;

   localparam logic [7:0] TMR_SEC_ADDR = 8'h41;
   localparam logic [7:0] TIMEOUT_DEF  = 8'd255;

   localparam logic [7:0] BCD_MAX_MS   = 8'h59;
   localparam logic [7:0] BCD_MAX_HR   = 8'h23;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_GAP_A,
      S_DATA,
      S_GAP_D,
      S_CHECK
   } state_e;

endpackage

// File: rtl/rtc_timer_reader_bcd_field_check.sv
// Checks one packed-BCD byte: both nibbles are decimal digits and value <= max.
// Ports: value_i (BCD byte), max_i (BCD upper limit), ok_o (1 = valid).
module bcd_field_check (
   input  logic [7:0] value_i,
   input  logic [7:0] max_i,
   output logic       ok_o
);

   // With both digits valid, the raw byte compare matches decimal order.
   assign ok_o = (value_i[3:0] <= 4'd9) &&
                 (value_i[7:4] <= 4'd9) &&
                 (value_i <= max_i);

endmodule

// File: rtl/rtc_timer_reader.sv
// Reads timer seconds/minutes/hours over the multiplexed RTC bus and
// publishes a validated BCD snapshot.
// Ports: clk, reset (sync, high); start; bus req_o/a_d_o/rd_o/dir_o,
// ack_i/data_i; snapshot seg_o/min_o/hor_o; status busy_o/done_o/err_o.
module rtc_timer_reader
   import rtc_timer_reader_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR = TMR_SEC_ADDR,
   parameter logic [7:0] TIMEOUT   = TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       req_o,
   output logic       a_d_o,
   output logic       rd_o,
   output logic [7:0] dir_o,
   input  logic       ack_i,
   input  logic [7:0] data_i,
   output logic [7:0] seg_o,
   output logic [7:0] min_o,
   output logic [7:0] hor_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o
);

   state_e     state_q;
   logic [1:0] idx_q;
   logic [1:0] idx_d;
   logic [7:0] cnt_q;
   logic [7:0] cnt_d;
   logic [7:0] sh_sec_q;
   logic [7:0] sh_min_q;
   logic [7:0] sh_hr_q;
   logic [7:0] seg_q;
   logic [7:0] min_q;
   logic [7:0] hor_q;
   logic [7:0] dir_q;
   logic       req_q;
   logic       a_d_q;
   logic       rd_q;
   logic       busy_q;
   logic       done_q;
   logic       err_q;
   logic       sec_ok;
   logic       min_ok;
   logic       hr_ok;

   assign idx_d = idx_q + 2'd1;
   assign cnt_d = cnt_q + 8'd1;

   bcd_field_check u_chk_sec (
      .value_i (sh_sec_q),
      .max_i   (BCD_MAX_MS),
      .ok_o    (sec_ok)
   );

   bcd_field_check u_chk_min (
      .value_i (sh_min_q),
      .max_i   (BCD_MAX_MS),
      .ok_o    (min_ok)
   );

   bcd_field_check u_chk_hr (
      .value_i (sh_hr_q),
      .max_i   (BCD_MAX_HR),
      .ok_o    (hr_ok)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= 2'd0;
         cnt_q    <= 8'd0;
         sh_sec_q <= 8'h00;
         sh_min_q <= 8'h00;
         sh_hr_q  <= 8'h00;
         seg_q    <= 8'h00;
         min_q    <= 8'h00;
         hor_q    <= 8'h00;
         dir_q    <= 8'h00;
         req_q    <= 1'b0;
         a_d_q    <= ADDR_PHASE;
         rd_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_ADDR;
                  idx_q   <= 2'd0;
                  cnt_q   <= 8'd0;
                  busy_q  <= 1'b1;
                  req_q   <= 1'b1;
                  a_d_q   <= ADDR_PHASE;
                  rd_q    <= 1'b0;
                  dir_q   <= BASE_ADDR;
               end
            end
            S_ADDR: begin
               // ack beats a timeout reached in the same cycle
               if (ack_i) begin
                  state_q <= S_GAP_A;
                  req_q   <= 1'b0;
               end else if (cnt_d == TIMEOUT) begin
                  state_q <= S_IDLE;
                  req_q   <= 1'b0;
                  a_d_q   <= ADDR_PHASE;
                  rd_q    <= 1'b0;
                  dir_q   <= 8'h00;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_GAP_A: begin
               state_q <= S_DATA;
               cnt_q   <= 8'd0;
               req_q   <= 1'b1;
               a_d_q   <= DATA_PHASE;
               rd_q    <= 1'b1;
               dir_q   <= 8'h00;
            end
            S_DATA: begin
               if (ack_i) begin
                  state_q <= S_GAP_D;
                  req_q   <= 1'b0;
                  unique case (idx_q)
                     2'd0:    sh_sec_q <= data_i;
                     2'd1:    sh_min_q <= data_i;
                     default: sh_hr_q  <= data_i;
                  endcase
               end else if (cnt_d == TIMEOUT) begin
                  state_q <= S_IDLE;
                  req_q   <= 1'b0;
                  a_d_q   <= ADDR_PHASE;
                  rd_q    <= 1'b0;
                  dir_q   <= 8'h00;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_GAP_D: begin
               if (idx_q == 2'd2) begin
                  state_q <= S_CHECK;
               end else begin
                  state_q <= S_ADDR;
                  idx_q   <= idx_d;
                  cnt_q   <= 8'd0;
                  req_q   <= 1'b1;
                  a_d_q   <= ADDR_PHASE;
                  rd_q    <= 1'b0;
                  dir_q   <= BASE_ADDR + {6'd0, idx_d};
               end
            end
            S_CHECK: begin
               // all three fields publish together or not at all
               if (sec_ok && min_ok && hr_ok) begin
                  seg_q  <= sh_sec_q;
                  min_q  <= sh_min_q;
                  hor_q  <= sh_hr_q;
                  done_q <= 1'b1;
               end else begin
                  err_q <= 1'b1;
               end
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               a_d_q   <= ADDR_PHASE;
               rd_q    <= 1'b0;
               dir_q   <= 8'h00;
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign req_o  = req_q;
   assign a_d_o  = a_d_q;
   assign rd_o   = rd_q;
   assign dir_o  = dir_q;
   assign seg_o  = seg_q;
   assign min_o  = min_q;
   assign hor_o  = hor_q;
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_rtc_timer_reader.sv
// Bench for rtc_timer_reader: table vectors, random snapshots checked
// against a decimal reference model, and timeout/reset/busy sequences.
module tb_rtc_timer_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       req_o;
   logic       a_d_o;
   logic       rd_o;
   logic [7:0] dir_o;
   logic       ack_i;
   logic [7:0] data_i;
   logic [7:0] seg_o;
   logic [7:0] min_o;
   logic [7:0] hor_o;
   logic       busy_o;
   logic       done_o;
   logic       err_o;

   rtc_timer_reader dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .req_o  (req_o),
      .a_d_o  (a_d_o),
      .rd_o   (rd_o),
      .dir_o  (dir_o),
      .ack_i  (ack_i),
      .data_i (data_i),
      .seg_o  (seg_o),
      .min_o  (min_o),
      .hor_o  (hor_o),
      .busy_o (busy_o),
      .done_o (done_o),
      .err_o  (err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] s;
      logic [7:0] m;
      logic [7:0] h;
      int         d;
      bit         ok;
      logic [7:0] es;
      logic [7:0] em;
      logic [7:0] eh;
   } vec_t;

   int         total = 0;
   int         bad   = 0;
   int         t;
   int         dly [6];
   logic [7:0] ms, mm, mh;

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, a, e);
      end
   endtask

   // Reference: a field is good when it reads as a decimal number <= lim.
   function automatic bit fld_ok(input logic [7:0] v, input int lim);
      int hi;
      int lo;
      hi = int'(v[7:4]);
      lo = int'(v[3:0]);
      return (hi <= 9) && (lo <= 9) && (hi * 10 + lo <= lim);
   endfunction

   function automatic logic [7:0] rnd_fld(input int lim);
      int n;
      if ($urandom_range(0, 3) == 0) return 8'($urandom);
      n = int'($urandom_range(0, lim));
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   task automatic step();
      @(negedge clk);
      t++;
   endtask

   task automatic do_phase(input int p, input logic [7:0] b,
                           input int d, output bit ok);
      int         w;
      int         drops;
      logic [7:0] ed;
      logic       ph;
      ok = 1'b0;
      w = 0;
      drops = 0;
      while (!req_o && w < 20) begin
         step();
         w++;
      end
      if (!req_o) begin
         chk($sformatf("req_wait%0d", p), 32'd0, 32'd1);
         return;
      end
      chk($sformatf("gap%0d", p), 32'(w), (p > 0) ? 32'd1 : 32'd0);
      ph = (p % 2) == 1;
      ed = ph ? 8'h00 : 8'h41 + 8'(p / 2);
      chk($sformatf("phase%0d", p),
          32'({busy_o, req_o, a_d_o, rd_o, dir_o}),
          32'({1'b1, 1'b1, ph, ph, ed}));
      for (int i = 0; i < d; i++) begin
         step();
         if (!req_o) drops++;
      end
      if (d > 0) chk($sformatf("hold%0d", p), 32'(drops), 32'd0);
      ack_i = 1'b1;
      data_i = ph ? b : 8'($urandom);
      step();
      ack_i = 1'b0;
      data_i = 8'h00;
      chk($sformatf("drop%0d", p), 32'(req_o), 32'd0);
      ok = 1'b1;
   endtask

   task automatic run_snap(input logic [7:0] s, input logic [7:0] m,
                           input logic [7:0] h, input bit poke,
                           input bit eok, input int elat);
      bit         ok;
      int         w;
      logic [7:0] b;
      @(negedge clk);
      start = 1'b1;
      t = 0;
      step();
      start = 1'b0;
      for (int p = 0; p < 6; p++) begin
         b = (p < 2) ? s : (p < 4) ? m : h;
         if (poke && p == 2) start = 1'b1;
         do_phase(p, b, dly[p], ok);
         start = 1'b0;
         if (!ok) return;
      end
      w = 0;
      while (!done_o && !err_o && w < 20) begin
         step();
         w++;
      end
      chk("result", 32'({done_o, err_o}), eok ? 32'd2 : 32'd1);
      chk("latency", 32'(t - 1), 32'(elat));
      chk("snapshot", 32'({seg_o, min_o, hor_o}), 32'({ms, mm, mh}));
      step();
      chk("pulse", 32'({done_o, err_o, busy_o, req_o}), 32'd0);
   endtask

   initial begin
      vec_t       tbl [9];
      bit         ok;
      bit         eok;
      int         lat;
      int         n0;
      int         cnt;
      logic [7:0] s, m, h;

      tbl[0] = '{8'h45, 8'h30, 8'h12, 0, 1'b1, 8'h45, 8'h30, 8'h12};
      tbl[1] = '{8'h5A, 8'h30, 8'h12, 0, 1'b0, 8'h45, 8'h30, 8'h12};
      tbl[2] = '{8'h59, 8'h59, 8'h23, 5, 1'b1, 8'h59, 8'h59, 8'h23};
      tbl[3] = '{8'h00, 8'h00, 8'h00, 1, 1'b1, 8'h00, 8'h00, 8'h00};
      tbl[4] = '{8'h10, 8'h60, 8'h05, 0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[5] = '{8'h3F, 8'h00, 8'h00, 2, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[6] = '{8'h12, 8'h34, 8'h24, 0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[7] = '{8'h09, 8'hA0, 8'h00, 0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[8] = '{8'h23, 8'h59, 8'h09, 3, 1'b1, 8'h23, 8'h59, 8'h09};

      reset = 1'b1;
      start = 1'b0;
      ack_i = 1'b0;
      data_i = 8'h00;
      t = 0;
      repeat (3) @(negedge clk);
      chk("reset", 32'({req_o, a_d_o, rd_o, busy_o, done_o, err_o, dir_o}),
          32'd0);
      chk("reset_snap", 32'({seg_o, min_o, hor_o}), 32'd0);
      reset = 1'b0;
      ms = 8'h00;
      mm = 8'h00;
      mh = 8'h00;

      // ack while idle must not start anything
      ack_i = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (req_o || busy_o) cnt++;
      end
      ack_i = 1'b0;
      chk("idle_ack", 32'(cnt), 32'd0);

      foreach (tbl[k]) begin
         for (int p = 0; p < 6; p++) dly[p] = tbl[k].d;
         ms = tbl[k].es;
         mm = tbl[k].em;
         mh = tbl[k].eh;
         run_snap(tbl[k].s, tbl[k].m, tbl[k].h, 1'b0, tbl[k].ok,
                  13 + 6 * tbl[k].d);
      end

      for (int k = 0; k < 30; k++) begin
         s = rnd_fld(59);
         m = rnd_fld(59);
         h = rnd_fld(23);
         lat = 13;
         for (int p = 0; p < 6; p++) begin
            dly[p] = int'($urandom_range(0, 4));
            lat += dly[p];
         end
         eok = fld_ok(s, 59) && fld_ok(m, 59) && fld_ok(h, 23);
         if (eok) begin
            ms = s;
            mm = m;
            mh = h;
         end
         run_snap(s, m, h, 1'b0, eok, lat);
      end

      // start held during a busy sequence is dropped
      for (int p = 0; p < 6; p++) dly[p] = 0;
      ms = 8'h11;
      mm = 8'h22;
      mh = 8'h03;
      run_snap(8'h11, 8'h22, 8'h03, 1'b1, 1'b1, 13);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done_o || req_o || busy_o) cnt++;
      end
      chk("no_extra", 32'(cnt), 32'd0);
      run_snap(8'h01, 8'h02, 8'h24, 1'b1, 1'b0, 13);

      // no ack in minutes address phase
      @(negedge clk);
      start = 1'b1;
      t = 0;
      step();
      start = 1'b0;
      do_phase(0, 8'h33, 0, ok);
      if (ok) do_phase(1, 8'h33, 0, ok);
      if (ok) begin
         n0 = t;
         while (!req_o && t - n0 < 20) step();
         chk("to_dir", 32'({req_o, a_d_o, dir_o}), 32'({2'b10, 8'h42}));
         n0 = t;
         cnt = 0;
         while (!err_o && t - n0 < 300) begin
            step();
            if (!err_o && !req_o) cnt++;
         end
         chk("to_lat", 32'(t - n0), 32'd255);
         chk("to_hold", 32'(cnt), 32'd0);
         chk("to_out", 32'({err_o, req_o, busy_o, done_o}), 32'b1000);
         chk("to_snap", 32'({seg_o, min_o, hor_o}), 32'({ms, mm, mh}));
      end

      // reset in data phase
      @(negedge clk);
      start = 1'b1;
      t = 0;
      step();
      start = 1'b0;
      do_phase(0, 8'h00, 0, ok);
      n0 = t;
      while (!req_o && t - n0 < 20) step();
      chk("in_data", 32'({req_o, a_d_o, rd_o}), 32'b111);
      reset = 1'b1;
      step();
      chk("rst_mid", 32'({req_o, busy_o, a_d_o, rd_o, done_o, err_o, dir_o}),
          32'd0);
      chk("rst_snap", 32'({seg_o, min_o, hor_o}), 32'd0);
      reset = 1'b0;
      ms = 8'h45;
      mm = 8'h30;
      mh = 8'h12;
      run_snap(8'h45, 8'h30, 8'h12, 1'b0, 1'b1, 13);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
